// File: rtl/UART_Types.sv
// Types and oversampling constants shared by the UART transmitter and receiver.
package UART_Types;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } Parity;

  typedef enum logic {
    STOP_1 = 1'b0,
    STOP_2 = 1'b1
  } StopBits;

  // Encoded as the bit count itself so the receiver can compare against it directly
  typedef enum logic [3:0] {
    BITS_6 = 4'd6,
    BITS_7 = 4'd7,
    BITS_8 = 4'd8
  } DataBits;

  localparam int         TICKS_PER_BIT = 16;
  localparam logic [3:0] TICK_LAST     = 4'(TICKS_PER_BIT - 1);
  localparam logic [3:0] VOTE_TICK_A   = 4'd7;
  localparam logic [3:0] VOTE_TICK_B   = 4'd8;
  localparam logic [3:0] VOTE_TICK_C   = 4'd9;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial input; presets to the idle-high line level.
module uart_rx_sync (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic meta;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      meta   <= 1'b1;
      o_sync <= 1'b1;
    end else begin
      meta   <= i_async;
      o_sync <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 3-sample majority vote, MSB-first data, optional parity,
// one or two stop bits, single-byte holding register with sticky overrun.
import UART_Types::*;

module uart_rx (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_rx,
  input  logic       i_ce,
  input  Parity      i_parity,
  input  StopBits    i_stopBits,
  input  DataBits    i_dataBits,
  input  logic       i_re,
  output logic [7:0] o_data,
  output logic       o_rdy,
  output logic       o_parityErr,
  output logic       o_frameErr,
  output logic       o_overrun,
  output logic       o_busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t     state, state_n;
  logic       rx_s, rx_prev;
  logic [3:0] tick, bit_cnt;
  logic       samp_a, samp_b;
  logic [7:0] shreg;
  logic       par_err, frm_err, done;
  Parity      cfg_par;
  StopBits    cfg_stop;
  DataBits    cfg_bits;
  logic       vote, vote_now, bit_end, last_bit;

  uart_rx_sync u_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_async (i_rx),
    .o_sync  (rx_s)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    vote     = majority3(samp_a, samp_b, rx_s);
    vote_now = i_ce && (tick == VOTE_TICK_C);
    bit_end  = i_ce && (tick == TICK_LAST);
    last_bit = (bit_cnt == cfg_bits - 4'd1);
    state_n  = state;
    case (state)
      IDLE:   if (i_ce && rx_prev && !rx_s) state_n = START;
      START: begin
        if (vote_now && vote) state_n = IDLE;
        else if (bit_end)     state_n = DATA;
      end
      DATA:   if (bit_end && last_bit) state_n = (cfg_par != PARITY_NONE) ? PARITY : STOP1;
      PARITY: if (bit_end) state_n = STOP1;
      STOP1: begin
        if (done)                              state_n = IDLE;
        else if (bit_end && cfg_stop == STOP_2) state_n = STOP2;
      end
      STOP2:  if (done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Config is captured continuously in IDLE, so it is frozen for the whole frame.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_prev  <= 1'b1;
      tick     <= '0;
      bit_cnt  <= '0;
      samp_a   <= 1'b0;
      samp_b   <= 1'b0;
      shreg    <= '0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
      done     <= 1'b0;
      cfg_par  <= PARITY_NONE;
      cfg_stop <= STOP_1;
      cfg_bits <= BITS_8;
    end else begin
      if (i_ce) rx_prev <= rx_s;
      done <= 1'b0;
      if (state == IDLE) begin
        cfg_par  <= i_parity;
        cfg_stop <= i_stopBits;
        cfg_bits <= i_dataBits;
        tick     <= '0;
        bit_cnt  <= '0;
        shreg    <= '0;
        par_err  <= 1'b0;
        frm_err  <= 1'b0;
      end else if (i_ce && !done) begin
        tick <= tick + 4'd1;
        if (tick == VOTE_TICK_A) samp_a <= rx_s;
        if (tick == VOTE_TICK_B) samp_b <= rx_s;
        if (vote_now) begin
          case (state)
            DATA:   shreg   <= {shreg[6:0], vote};
            PARITY: par_err <= ((^shreg) ^ vote) != (cfg_par == PARITY_ODD);
            STOP1: begin
              if (!vote) frm_err <= 1'b1;
              if (cfg_stop == STOP_1) done <= 1'b1;
            end
            STOP2: begin
              if (!vote) frm_err <= 1'b1;
              done <= 1'b1;
            end
            default: ;
          endcase
        end
        if (bit_end && state == DATA) bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_data      <= '0;
      o_rdy       <= 1'b0;
      o_parityErr <= 1'b0;
      o_frameErr  <= 1'b0;
      o_overrun   <= 1'b0;
    end else if (done) begin
      o_data      <= shreg;
      o_parityErr <= par_err;
      o_frameErr  <= frm_err;
      o_rdy       <= 1'b1;
      if (o_rdy && !i_re) o_overrun <= 1'b1;
    end else if (i_re && o_rdy) begin
      o_rdy <= 1'b0;
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: framing, parity, stop errors, false start, overrun, reset.
import UART_Types::*;

module tb_uart_rx;

  logic       i_clock = 1'b0;
  logic       i_reset;
  logic       i_rx;
  logic       i_ce = 1'b0;
  Parity      i_parity;
  StopBits    i_stopBits;
  DataBits    i_dataBits;
  logic       i_re;
  logic [7:0] o_data;
  logic       o_rdy, o_parityErr, o_frameErr, o_overrun, o_busy;

  int checks = 0;
  int errors = 0;

  uart_rx dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_rx        (i_rx),
    .i_ce        (i_ce),
    .i_parity    (i_parity),
    .i_stopBits  (i_stopBits),
    .i_dataBits  (i_dataBits),
    .i_re        (i_re),
    .o_data      (o_data),
    .o_rdy       (o_rdy),
    .o_parityErr (o_parityErr),
    .o_frameErr  (o_frameErr),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy)
  );

  initial forever #5 i_clock = ~i_clock;

  // Sample tick: one clock high out of every four.
  initial forever begin
    repeat (3) @(negedge i_clock);
    i_ce = 1'b1;
    @(negedge i_clock);
    i_ce = 1'b0;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clock);
      while (!i_ce) @(posedge i_clock);
    end
    #1;
  endtask

  task automatic send_bit(input logic v);
    i_rx = v;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input int n, input logic use_par,
                            input logic par_bit, input int nstop, input logic stop_val);
    send_bit(1'b0);
    for (int i = n - 1; i >= 0; i--) send_bit(d[i]);
    if (use_par) send_bit(par_bit);
    send_bit(stop_val);
    if (nstop == 2) send_bit(1'b1);
    i_rx = 1'b1;
    wait_ticks(2);
  endtask

  task automatic read_byte();
    @(negedge i_clock);
    i_re = 1'b1;
    @(posedge i_clock);
    #1;
    i_re = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_data"}, o_data, 8'h00);
    check({tag, "_rdy"}, {7'd0, o_rdy}, 8'h00);
    check({tag, "_perr"}, {7'd0, o_parityErr}, 8'h00);
    check({tag, "_ferr"}, {7'd0, o_frameErr}, 8'h00);
    check({tag, "_ovr"}, {7'd0, o_overrun}, 8'h00);
    check({tag, "_busy"}, {7'd0, o_busy}, 8'h00);
  endtask

  initial begin
    i_reset    = 1'b1;
    i_rx       = 1'b1;
    i_re       = 1'b0;
    i_parity   = PARITY_NONE;
    i_stopBits = STOP_1;
    i_dataBits = BITS_8;
    repeat (4) @(posedge i_clock);
    #1;
    check_cleared("reset");
    i_reset = 1'b0;
    wait_ticks(4);

    // 8N1 0xA5
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
    check("a5_rdy", {7'd0, o_rdy}, 8'h01);
    check("a5_data", o_data, 8'hA5);
    check("a5_perr", {7'd0, o_parityErr}, 8'h00);
    check("a5_ferr", {7'd0, o_frameErr}, 8'h00);
    check("a5_busy", {7'd0, o_busy}, 8'h00);
    read_byte();
    check("a5_read_rdy", {7'd0, o_rdy}, 8'h00);

    // 7E2 0x35: four ones, even parity bit is 0
    i_parity   = PARITY_EVEN;
    i_stopBits = STOP_2;
    i_dataBits = BITS_7;
    wait_ticks(2);
    send_frame(8'h35, 7, 1'b1, 1'b0, 2, 1'b1);
    check("e2_ok_data", o_data, 8'h35);
    check("e2_ok_perr", {7'd0, o_parityErr}, 8'h00);
    check("e2_ok_ferr", {7'd0, o_frameErr}, 8'h00);
    read_byte();
    send_frame(8'h35, 7, 1'b1, 1'b1, 2, 1'b1);
    check("e2_bad_data", o_data, 8'h35);
    check("e2_bad_perr", {7'd0, o_parityErr}, 8'h01);
    check("e2_bad_rdy", {7'd0, o_rdy}, 8'h01);
    read_byte();

    // 8N1 with stop bit low
    i_parity   = PARITY_NONE;
    i_stopBits = STOP_1;
    i_dataBits = BITS_8;
    wait_ticks(2);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1, 1'b0);
    check("ferr_flag", {7'd0, o_frameErr}, 8'h01);
    check("ferr_data", o_data, 8'hC3);
    check("ferr_rdy", {7'd0, o_rdy}, 8'h01);
    read_byte();
    wait_ticks(8);

    // 5-tick low glitch
    i_rx = 1'b0;
    wait_ticks(3);
    check("glitch_busy_hi", {7'd0, o_busy}, 8'h01);
    wait_ticks(2);
    i_rx = 1'b1;
    wait_ticks(20);
    check("glitch_busy_lo", {7'd0, o_busy}, 8'h00);
    check("glitch_rdy", {7'd0, o_rdy}, 8'h00);

    // Back-to-back frames without reading
    send_frame(8'h11, 8, 1'b0, 1'b0, 1, 1'b1);
    check("ovr_first_ovr", {7'd0, o_overrun}, 8'h00);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1, 1'b1);
    check("ovr_data", o_data, 8'h22);
    check("ovr_flag", {7'd0, o_overrun}, 8'h01);
    read_byte();
    check("ovr_read_rdy", {7'd0, o_rdy}, 8'h00);
    check("ovr_read_flag", {7'd0, o_overrun}, 8'h01);
    check("ovr_read_data", o_data, 8'h22);

    // Reset midway through data bit 3 of 0x96
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    i_rx = 1'b0;
    wait_ticks(8);
    check("mid_busy", {7'd0, o_busy}, 8'h01);
    @(negedge i_clock);
    i_reset = 1'b1;
    i_rx    = 1'b1;
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    check_cleared("midrst");
    wait_ticks(20);
    check("midrst_idle_rdy", {7'd0, o_rdy}, 8'h00);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1);
    check("post_rst_data", o_data, 8'h5A);
    check("post_rst_rdy", {7'd0, o_rdy}, 8'h01);
    check("post_rst_perr", {7'd0, o_parityErr}, 8'h00);
    check("post_rst_ferr", {7'd0, o_frameErr}, 8'h00);
    check("post_rst_ovr", {7'd0, o_overrun}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
